motor_move_ctrl: RTL and testbench

Sequences point-to-point moves for six stepper motors from the operator-entry stage. On a committed command (one-hot motor select plus a 3-digit BCD target), it converts the target to binary and compares it with that motor's tracked position. It then emits paced step/dir pulses on the selected motor until the position matches. One move is in flight at a time; the block sits between the keypad entry stage and the motor driver pins.

---
 rtl/motor_pkg.sv | 34 +++
 rtl/motor_move_ctrl_if.sv | 43 ++++
 rtl/motor_move_ctrl_bcd3_to_bin.sv | 17 +
 rtl/motor_move_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_motor_move_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor move controller: sizes, the move-sequencer
// state encoding and small one-hot helpers used by the controller and its bench.
package motor_pkg;

    localparam int unsigned NUM_MOTORS = 6;
    localparam int unsigned POS_W      = 10;
    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned IDX_W      = $clog2(NUM_MOTORS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        STEP_HI = 3'd3,
        STEP_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    // True when exactly one bit of the motor select is set.
    function automatic logic is_onehot(input logic [NUM_MOTORS-1:0] v);
        return (v != '0) && ((v & (v - NUM_MOTORS'(1))) == '0);
    endfunction

    // Index of the set bit of a one-hot select (highest set bit otherwise).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MOTORS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/motor_move_ctrl_if.sv
// Command/driver bundle between keypad entry, the move controller and the
// motor driver pins.
//   cmd_commit, Motor, TValue0..2 : command from entry stage
//   abort                         : move cancel (only when ABORT_EN is defined)
//   step_out, dir_out             : per-motor driver pins
//   busy, done, err               : status to the entry stage
// Optional feature macro: ABORT_EN.
interface motor_move_ctrl_if
    import motor_pkg::*;
;
    logic                  cmd_commit;
    logic [NUM_MOTORS-1:0] Motor;
    logic [3:0]            TValue0;
    logic [3:0]            TValue1;
    logic [3:0]            TValue2;
`ifdef ABORT_EN
    logic                  abort;
`endif
    logic [NUM_MOTORS-1:0] step_out;
    logic [NUM_MOTORS-1:0] dir_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Command source side (entry stage / bench).
    modport master (
`ifdef ABORT_EN
        output abort,
`endif
        output cmd_commit, Motor, TValue0, TValue1, TValue2,
        input  step_out, dir_out, busy, done, err
    );

    // Controller side.
    modport slave (
`ifdef ABORT_EN
        input  abort,
`endif
        input  cmd_commit, Motor, TValue0, TValue1, TValue2,
        output step_out, dir_out, busy, done, err
    );

endinterface

// File: rtl/motor_move_ctrl_bcd3_to_bin.sv
// Combinational 3-digit BCD to binary conversion (also used by the display path).
//   i_hund, i_tens, i_units : BCD digits
//   o_bin                   : 100*hund + 10*tens + units at POS_W width
module bcd3_to_bin
    import motor_pkg::*;
(
    input  logic [3:0]       i_hund,
    input  logic [3:0]       i_tens,
    input  logic [3:0]       i_units,
    output logic [POS_W-1:0] o_bin
);

    assign o_bin = POS_W'(i_hund) * POS_W'(100)
                 + POS_W'(i_tens) * POS_W'(10)
                 + POS_W'(i_units);

endmodule

// File: rtl/motor_move_ctrl.sv
// Point-to-point move sequencer for six stepper motors. A rising edge on
// cmd_commit latches a one-hot motor select and a 3-digit BCD target; the block
// then steps the selected motor (paced step/dir) until its tracked position
// equals the target.
//   sysclk : system clock, rising edge
//   rst    : asynchronous active-low reset
//   bus    : motor_move_ctrl_if.slave (command in, step/dir/status out)
// Optional feature macro: ABORT_EN (adds bus.abort move cancel).
module motor_move_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1000,
    parameter int unsigned PULSE_W  = 10
) (
    input  logic               sysclk,
    input  logic               rst,
    motor_move_ctrl_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(STEP_DIV);

    state_t                r_state;
    logic                  r_commit;
    logic [NUM_MOTORS-1:0] r_motor;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_d0;
    logic [3:0]            r_d1;
    logic [3:0]            r_d2;
    logic [POS_W-1:0]      r_target;
    logic [POS_W-1:0]      r_pos [NUM_MOTORS];
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_MOTORS-1:0] r_step;
    logic [NUM_MOTORS-1:0] r_dir;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_abort_pend;

    logic                  w_start;
    logic                  w_bad_cmd;
    logic                  w_abort;
    logic [POS_W-1:0]      w_target;

    assign w_start   = bus.cmd_commit & ~r_commit;
    assign w_bad_cmd = !is_onehot(bus.Motor)
                     || (bus.TValue0 > 4'(BCD_MAX))
                     || (bus.TValue1 > 4'(BCD_MAX))
                     || (bus.TValue2 > 4'(BCD_MAX));

`ifdef ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    bcd3_to_bin u_bcd (
        .i_hund  (r_d0),
        .i_tens  (r_d1),
        .i_units (r_d2),
        .o_bin   (w_target)
    );

    // Move sequencer; r_cnt is the single pacing counter, cleared on every state entry.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_commit     <= 1'b0;
            r_motor      <= '0;
            r_idx        <= '0;
            r_d0         <= '0;
            r_d1         <= '0;
            r_d2         <= '0;
            r_target     <= '0;
            r_cnt        <= '0;
            r_step       <= '0;
            r_dir        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) r_pos[i] <= '0;
        end else begin
            r_commit <= bus.cmd_commit;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            // Step pin trails the state by one cycle so dir settles a cycle before the rising edge.
            r_step   <= (r_state == STEP_HI) ? r_motor : '0;

            case (r_state)
                IDLE: begin
                    r_cnt        <= '0;
                    r_abort_pend <= 1'b0;
                    if (w_start) begin
                        r_motor <= bus.Motor;
                        r_d0    <= bus.TValue0;
                        r_d1    <= bus.TValue1;
                        r_d2    <= bus.TValue2;
                        r_idx   <= onehot_to_idx(bus.Motor);
                        if (w_bad_cmd) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    r_cnt    <= '0;
                    r_target <= w_target;
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= CHECK;
                    end
                end

                CHECK: begin
                    r_cnt <= '0;
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (r_target == r_pos[r_idx]) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_dir[r_idx] <= (r_target > r_pos[r_idx]);
                        r_state      <= STEP_HI;
                    end
                end

                STEP_HI: begin
                    // An abort during the pulse is remembered and honoured once the step is counted.
                    if (w_abort) r_abort_pend <= 1'b1;
                    if (r_cnt == CNT_W'(PULSE_W - 1)) begin
                        r_cnt <= '0;
                        if (r_dir[r_idx]) r_pos[r_idx] <= r_pos[r_idx] + POS_W'(1);
                        else              r_pos[r_idx] <= r_pos[r_idx] - POS_W'(1);
                        if (w_abort || r_abort_pend) begin
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_err        <= 1'b1;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state <= STEP_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STEP_LO: begin
                    if (w_abort) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (r_cnt == CNT_W'(STEP_DIV - PULSE_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step_out = r_step;
    assign bus.dir_out  = r_dir;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// Directed bench for motor_move_ctrl with STEP_DIV=8, PULSE_W=2 (step period 9).
module tb_motor_move_ctrl;
    import motor_pkg::*;

    localparam int PER = 9;
    localparam int PW  = 2;

    logic sysclk = 1'b0;
    logic rst    = 1'b0;
    always #5 sysclk = ~sysclk;

    motor_move_ctrl_if bus ();

    motor_move_ctrl #(.STEP_DIV(8), .PULSE_W(2)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge sysclk) cyc++;

    // Pin monitor: pulse counts, pulse widths, pulse spacing and dir set-up.
    int rises [NUM_MOTORS];
    int hi_len [NUM_MOTORS];
    int last_rise [NUM_MOTORS];
    int width_bad = 0;
    int period_bad = 0;
    int dir_late = 0;
    logic [NUM_MOTORS-1:0] prev_step = '0;
    logic [NUM_MOTORS-1:0] prev_dir  = '0;

    always @(negedge sysclk) begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (bus.step_out[i] === 1'b1 && prev_step[i] === 1'b0) begin
                if (prev_dir[i] !== bus.dir_out[i]) dir_late++;
                if (rises[i] > 0 && (cyc - last_rise[i]) != PER) period_bad++;
                rises[i]++;
                last_rise[i] = cyc;
                hi_len[i] = 1;
            end else if (bus.step_out[i] === 1'b1) begin
                hi_len[i]++;
            end else if (prev_step[i] === 1'b1) begin
                if (hi_len[i] != PW) width_bad++;
            end
        end
        prev_step = bus.step_out;
        prev_dir  = bus.dir_out;
    end

    task automatic clear_mon();
        for (int i = 0; i < NUM_MOTORS; i++) begin
            rises[i] = 0;
            hi_len[i] = 0;
        end
        width_bad = 0;
        period_bad = 0;
        dir_late = 0;
    endtask

    function automatic int total_rises();
        int s;
        s = 0;
        for (int i = 0; i < NUM_MOTORS; i++) s += rises[i];
        return s;
    endfunction

    task automatic issue(input logic [5:0] m, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(posedge sysclk);
        #1;
        bus.Motor = m;
        bus.TValue0 = a;
        bus.TValue1 = b;
        bus.TValue2 = c;
        bus.cmd_commit = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int lat, output int busy_cnt, output int err_cnt);
        lat = -1;
        busy_cnt = 0;
        err_cnt = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge sysclk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.err === 1'b1) err_cnt++;
            if (bus.done === 1'b1) begin
                lat = cyc - start_cyc;
                break;
            end
        end
    endtask

    task automatic run_move(input logic [5:0] m, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            output int lat, output int busy_cnt, output int err_cnt);
        clear_mon();
        issue(m, a, b, c);
        wait_done(1000, lat, busy_cnt, err_cnt);
        bus.cmd_commit = 1'b0;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_reset();
        bus.cmd_commit = 1'b0;
        bus.Motor = '0;
        bus.TValue0 = '0;
        bus.TValue1 = '0;
        bus.TValue2 = '0;
`ifdef ABORT_EN
        bus.abort = 1'b0;
`endif
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++; if (bus.step_out !== 6'b0) begin errors++; $display("FAIL reset_step got %b want 000000", bus.step_out); end
        checks++; if (bus.dir_out !== 6'b0) begin errors++; $display("FAIL reset_dir got %b want 000000", bus.dir_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_zero_move();
        int lat, bc, ec;
        run_move(6'b000001, 4'd0, 4'd0, 4'd0, lat, bc, ec);
        checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
        checks++; if (bc != 3) begin errors++; $display("FAIL zero_busy_cycles got %0d want 3", bc); end
        checks++; if (total_rises() != 0) begin errors++; $display("FAIL zero_steps got %0d want 0", total_rises()); end
        // One unit move on motor 1 proves its position stayed 0.
        run_move(6'b000001, 4'd0, 4'd0, 4'd1, lat, bc, ec);
        checks++; if (lat != 3 + PER) begin errors++; $display("FAIL m1_one_latency got %0d want %0d", lat, 3 + PER); end
        checks++; if (rises[0] != 1) begin errors++; $display("FAIL m1_one_steps got %0d want 1", rises[0]); end
        checks++; if (bus.dir_out !== 6'b000001) begin errors++; $display("FAIL m1_dir got %b want 000001", bus.dir_out); end
    endtask

    task automatic test_forward();
        int lat, bc, ec;
        run_move(6'b000100, 4'd0, 4'd0, 4'd5, lat, bc, ec);
        checks++; if (lat != 3 + 5 * PER) begin errors++; $display("FAIL fwd_latency got %0d want %0d", lat, 3 + 5 * PER); end
        checks++; if (rises[2] != 5) begin errors++; $display("FAIL fwd_steps got %0d want 5", rises[2]); end
        checks++; if (total_rises() != 5) begin errors++; $display("FAIL fwd_other_steps got %0d want 0", total_rises() - rises[2]); end
        checks++; if (width_bad != 0) begin errors++; $display("FAIL fwd_width bad pulses %0d want 0", width_bad); end
        checks++; if (period_bad != 0) begin errors++; $display("FAIL fwd_period bad gaps %0d want 0", period_bad); end
        checks++; if (dir_late != 0) begin errors++; $display("FAIL fwd_dir_setup late %0d want 0", dir_late); end
        checks++; if (bus.dir_out !== 6'b000101) begin errors++; $display("FAIL fwd_dir got %b want 000101", bus.dir_out); end
        run_move(6'b000100, 4'd0, 4'd0, 4'd5, lat, bc, ec);
        checks++; if (lat != 3) begin errors++; $display("FAIL fwd_repeat_latency got %0d want 3", lat); end
        checks++; if (total_rises() != 0) begin errors++; $display("FAIL fwd_repeat_steps got %0d want 0", total_rises()); end
    endtask

    task automatic test_reverse();
        int lat, bc, ec;
        run_move(6'b000100, 4'd0, 4'd0, 4'd2, lat, bc, ec);
        checks++; if (lat != 3 + 3 * PER) begin errors++; $display("FAIL rev_latency got %0d want %0d", lat, 3 + 3 * PER); end
        checks++; if (rises[2] != 3) begin errors++; $display("FAIL rev_steps got %0d want 3", rises[2]); end
        checks++; if (total_rises() != 3) begin errors++; $display("FAIL rev_other_steps got %0d want 0", total_rises() - rises[2]); end
        checks++; if (bus.dir_out !== 6'b000001) begin errors++; $display("FAIL rev_dir got %b want 000001", bus.dir_out); end
        checks++; if (width_bad != 0 || period_bad != 0) begin errors++; $display("FAIL rev_timing width %0d period %0d want 0 0", width_bad, period_bad); end
    endtask

    task automatic test_reject();
        logic [5:0] mv [3];
        logic [3:0] hv [3];
        int ec, bc, first;
        mv[0] = 6'b000011; hv[0] = 4'd0;
        mv[1] = 6'b000000; hv[1] = 4'd0;
        mv[2] = 6'b000001; hv[2] = 4'hA;
        for (int v = 0; v < 3; v++) begin
            clear_mon();
            issue(mv[v], hv[v], 4'd0, 4'd1);
            ec = 0; bc = 0; first = -1;
            for (int k = 0; k < 6; k++) begin
                @(negedge sysclk);
                if (bus.err === 1'b1) begin
                    ec++;
                    if (first < 0) first = cyc - start_cyc;
                end
                if (bus.busy === 1'b1) bc++;
            end
            bus.cmd_commit = 1'b0;
            @(negedge sysclk);
            checks++; if (ec != 1) begin errors++; $display("FAIL reject%0d_err_count got %0d want 1", v, ec); end
            checks++; if (first != 1) begin errors++; $display("FAIL reject%0d_err_time got %0d want 1", v, first); end
            checks++; if (bc != 0 || total_rises() != 0) begin errors++; $display("FAIL reject%0d_idle busy %0d steps %0d want 0 0", v, bc, total_rises()); end
        end
    endtask

    task automatic test_busy_level();
        int lat, bc, ec, nb, nd, ne;
        clear_mon();
        issue(6'b000100, 4'd0, 4'd0, 4'd4);
        repeat (10) @(negedge sysclk);
        bus.cmd_commit = 1'b0;
        @(negedge sysclk);
        bus.cmd_commit = 1'b1;
        wait_done(200, lat, bc, ec);
        checks++; if (lat != 3 + 2 * PER) begin errors++; $display("FAIL busy_latency got %0d want %0d", lat, 3 + 2 * PER); end
        checks++; if (rises[2] != 2 || ec != 0) begin errors++; $display("FAIL busy_ignore steps %0d err %0d want 2 0", rises[2], ec); end
        clear_mon();
        nb = 0; nd = 0; ne = 0;
        repeat (100) begin
            @(negedge sysclk);
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) nd++;
            if (bus.err === 1'b1) ne++;
        end
        bus.cmd_commit = 1'b0;
        repeat (2) @(negedge sysclk);
        checks++; if (nb != 0 || nd != 0 || ne != 0 || total_rises() != 0) begin
            errors++; $display("FAIL level_hold busy %0d done %0d err %0d steps %0d want all 0", nb, nd, ne, total_rises());
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, ec;
        bit seen;
        clear_mon();
        issue(6'b000010, 4'd0, 4'd0, 4'd3);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sysclk);
            if (bus.step_out[1] === 1'b1) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_pulse_seen got 0 want 1"); end
        #2;
        bus.cmd_commit = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.step_out !== 6'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop step %b busy %b want 000000 0", bus.step_out, bus.busy);
        end
        @(negedge sysclk);
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        run_move(6'b000010, 4'd0, 4'd1, 4'd0, lat, bc, ec);
        checks++; if (lat != 3 + 10 * PER) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", lat, 3 + 10 * PER); end
        checks++; if (rises[1] != 10) begin errors++; $display("FAIL rstmid_steps got %0d want 10", rises[1]); end
        run_move(6'b000100, 4'd0, 4'd0, 4'd1, lat, bc, ec);
        checks++; if (rises[2] != 1 || bus.dir_out[2] !== 1'b1) begin
            errors++; $display("FAIL rstmid_m3_cleared steps %0d dir %b want 1 1", rises[2], bus.dir_out[2]);
        end
    endtask

`ifdef ABORT_EN
    task automatic test_abort();
        int lat, bc, ec, nd, errs;
        bit was_hi, in_lo;
        clear_mon();
        issue(6'b000100, 4'd0, 4'd0, 4'd9);
        was_hi = 0; in_lo = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge sysclk);
            if (bus.step_out[2] === 1'b1) was_hi = 1;
            else if (was_hi) begin in_lo = 1; break; end
        end
        checks++; if (!in_lo) begin errors++; $display("FAIL abort_reach_lo got 0 want 1"); end
        bus.abort = 1'b1;
        @(negedge sysclk);
        bus.abort = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_exit err %b busy %b want 1 0", bus.err, bus.busy);
        end
        nd = 0; errs = 0;
        repeat (20) begin
            @(negedge sysclk);
            if (bus.done === 1'b1) nd++;
            if (bus.err === 1'b1) errs++;
        end
        bus.cmd_commit = 1'b0;
        checks++; if (nd != 0 || errs != 0 || rises[2] != 1) begin
            errors++; $display("FAIL abort_after done %0d err %0d steps %0d want 0 0 1", nd, errs, rises[2]);
        end
        run_move(6'b000100, 4'd0, 4'd0, 4'd1, lat, bc, ec);
        checks++; if (lat != 3 + PER || bus.dir_out[2] !== 1'b0) begin
            errors++; $display("FAIL abort_pos latency %0d dir %b want %0d 0", lat, bus.dir_out[2], 3 + PER);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            rises[i] = 0;
            hi_len[i] = 0;
            last_rise[i] = 0;
        end
        test_reset();
        test_zero_move();
        test_forward();
        test_reverse();
        test_reject();
        test_busy_level();
        test_reset_mid();
`ifdef ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
